// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One operation in flight, one result bit per cycle: W iteration cycles plus
// one finish cycle in which HI/LO are written and done pulses.
// Optional feature: define MULDIV_DIV0_FLAG_EN to add the sticky-per-result
// div0 output, which flags a divide whose divisor was zero.
module muldiv_unit #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
`ifdef MULDIV_DIV0_FLAG_EN
  ,
  output logic         div0
`endif
);

  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

  localparam logic [2:0] OpMult  = 3'b001;
  localparam logic [2:0] OpMultu = 3'b010;
  localparam logic [2:0] OpDiv   = 3'b011;
  localparam logic [2:0] OpDivu  = 3'b100;
  localparam logic [2:0] OpMthi  = 3'b101;
  localparam logic [2:0] OpMtlo  = 3'b110;

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [W-1:0]      hi_q, hi_d;
  logic [W-1:0]      lo_q, lo_d;
  // work_hi: running partial product / remainder; work_lo: multiplier / quotient.
  logic [W-1:0]      work_hi_q, work_hi_d;
  logic [W-1:0]      work_lo_q, work_lo_d;
  // Multiplicand or divisor magnitude.
  logic [W-1:0]      opnd_q, opnd_d;
  logic              is_div_q, is_div_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              b_zero_q, b_zero_d;
`ifdef MULDIV_DIV0_FLAG_EN
  logic              div0_q, div0_d;
`endif

  // Operand decode and per-iteration datapath.
  logic              is_muldiv_op, is_div_op, signed_op;
  logic [W-1:0]      a_mag, b_mag;
  logic [W:0]        mul_sum;
  logic [W:0]        div_shift;
  logic              div_ge;
  logic [W-1:0]      div_diff;
  logic [2*W-1:0]    prod, prod_fix;
  logic [W-1:0]      quo_fix, rem_fix;

  assign is_div_op    = (op == OpDiv) || (op == OpDivu);
  assign is_muldiv_op = (op == OpMult) || (op == OpMultu) || is_div_op;
  assign signed_op    = (op == OpMult) || (op == OpDiv);
  assign a_mag        = (signed_op && a[W-1]) ? -a : a;
  assign b_mag        = (signed_op && b[W-1]) ? -b : b;

  // Shift-add step: add multiplicand when the multiplier LSB is set, then shift right.
  assign mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
  // Restoring step: shift in next dividend bit, subtract divisor if it fits.
  assign div_shift = {work_hi_q, work_lo_q[W-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  // Result is below the divisor whenever it is used, so W bits suffice.
  assign div_diff  = div_shift[W-1:0] - opnd_q;

  assign prod     = {work_hi_q, work_lo_q};
  assign prod_fix = neg_res_q ? -prod : prod;
  assign quo_fix  = neg_res_q ? -work_lo_q : work_lo_q;
  assign rem_fix  = neg_rem_q ? -work_hi_q : work_hi_q;

  // Next-state logic for the FSM, datapath and architectural registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    b_zero_d  = b_zero_q;
`ifdef MULDIV_DIV0_FLAG_EN
    div0_d    = div0_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          if (is_muldiv_op) begin
            state_d   = StRun;
            busy_d    = 1'b1;
            cnt_d     = '0;
            is_div_d  = is_div_op;
            work_hi_d = '0;
            work_lo_d = is_div_op ? a_mag : b_mag;
            opnd_d    = is_div_op ? b_mag : a_mag;
            neg_res_d = signed_op && (a[W-1] ^ b[W-1]);
            neg_rem_d = (op == OpDiv) && a[W-1];
            b_zero_d  = is_div_op && (b == '0);
          end else if (op == OpMthi) begin
            hi_d = a;
          end else if (op == OpMtlo) begin
            lo_d = a;
          end
        end
      end
      StRun: begin
        if (flush) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          if (is_div_q) begin
            work_hi_d = div_ge ? div_diff : div_shift[W-1:0];
            work_lo_d = {work_lo_q[W-2:0], div_ge};
          end else begin
            work_hi_d = mul_sum[W:1];
            work_lo_d = {mul_sum[0], work_lo_q[W-1:1]};
          end
          if (cnt_q == CntLast) begin
            state_d = StFinish;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StFinish: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        if (!flush) begin
          done_d = 1'b1;
          // Divide by zero leaves HI/LO untouched.
          if (!b_zero_q) begin
            if (is_div_q) begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end else begin
              {hi_d, lo_d} = prod_fix;
            end
          end
`ifdef MULDIV_DIV0_FLAG_EN
          div0_d = b_zero_q;
`endif
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
      div0_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      b_zero_q  <= b_zero_d;
`ifdef MULDIV_DIV0_FLAG_EN
      div0_q    <= div0_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
`ifdef MULDIV_DIV0_FLAG_EN
  assign div0 = div0_q;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO results,
// a monitor pops and compares them whenever done pulses.
module tb_muldiv_unit;
  localparam int unsigned W = 32;

  localparam logic [2:0] OpNop   = 3'b000;
  localparam logic [2:0] OpMult  = 3'b001;
  localparam logic [2:0] OpMultu = 3'b010;
  localparam logic [2:0] OpDiv   = 3'b011;
  localparam logic [2:0] OpDivu  = 3'b100;
  localparam logic [2:0] OpMthi  = 3'b101;
  localparam logic [2:0] OpMtlo  = 3'b110;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op = OpNop;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;
`ifdef MULDIV_DIV0_FLAG_EN
  logic         div0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  always #5 clk = ~clk;

  muldiv_unit #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
`ifdef MULDIV_DIV0_FLAG_EN
    ,
    .div0  (div0)
`endif
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input string name, input logic [W-1:0] h, input logic [W-1:0] l,
                      input logic d0);
    exp_t e;
    e.name = name;
    e.hi   = h;
    e.lo   = l;
    e.div0 = d0;
    sb.push_back(e);
  endtask

  // Drive one start cycle; operands are scrambled afterwards to prove they were latched.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
    op    = OpNop;
    a     = ~av;
    b     = ~bv;
  endtask

  // Count busy cycles until it drops (bounded), then check the one-cycle done pulse.
  task automatic run_to_done(input string name, input int exp_cycles);
    int cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, cnt, exp_cycles);
    check({name, "_done_high"}, done, 1'b1);
    @(negedge clk);
    check({name, "_done_low"}, done, 1'b0);
  endtask

  // Monitor: compare against the scoreboard whenever done is presented.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no result (t=%0t)", $time);
      end else begin
        cur = sb.pop_front();
        check({cur.name, "_hi"}, hi, cur.hi);
        check({cur.name, "_lo"}, lo, cur.lo);
`ifdef MULDIV_DIV0_FLAG_EN
        check({cur.name, "_div0"}, div0, cur.div0);
`endif
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
`ifdef MULDIV_DIV0_FLAG_EN
    check("rst_div0", div0, 0);
`endif

    // Signed multiply with mixed signs.
    push("mult_7_m3", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    issue(OpMult, 32'd7, 32'hFFFF_FFFD);
    check("mult_busy_after_accept", busy, 1);
    run_to_done("mult_7_m3", 33);

    push("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    issue(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_to_done("multu_max", 33);

    push("mult_m1_m1", 32'h0, 32'h1, 1'b0);
    issue(OpMult, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_to_done("mult_m1_m1", 33);

    // Divides.
    push("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    issue(OpDiv, 32'hFFFF_FFF9, 32'd2);
    run_to_done("div_m7_2", 33);

    push("divu_100_7", 32'd2, 32'd14, 1'b0);
    issue(OpDivu, 32'd100, 32'd7);
    run_to_done("divu_100_7", 33);

    push("div_ovf", 32'h0, 32'h8000_0000, 1'b0);
    issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    run_to_done("div_ovf", 33);

    // MTHI / MTLO, then divide by zero keeps them.
    issue(OpMthi, 32'h1234, 32'h0);
    check("mthi_hi", hi, 32'h1234);
    check("mthi_busy", busy, 0);
    check("mthi_done", done, 0);
    issue(OpMtlo, 32'h5678, 32'h0);
    check("mtlo_lo", lo, 32'h5678);
    check("mtlo_hi_kept", hi, 32'h1234);

    push("divu_by0", 32'h1234, 32'h5678, 1'b1);
    issue(OpDivu, 32'd5, 32'd0);
    run_to_done("divu_by0", 33);

    push("multu_2_3", 32'h0, 32'd6, 1'b0);
    issue(OpMultu, 32'd2, 32'd3);
    run_to_done("multu_2_3", 33);

    // Start during busy is ignored.
    push("multu_5_5", 32'h0, 32'd25, 1'b0);
    issue(OpMultu, 32'd5, 32'd5);
    repeat (2) @(negedge clk);
    issue(OpDivu, 32'd9, 32'd3);
    check("ignored_start_busy", busy, 1);
    run_to_done("multu_5_5", 29);

    // Flush on iteration 10.
    issue(OpMult, 32'd3, 32'd4);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_done", done, 0);
    check("flush_hi", hi, 32'h0);
    check("flush_lo", lo, 32'd25);
    issue(OpMtlo, 32'hAA, 32'h0);
    check("mtlo_after_flush", lo, 32'hAA);

    // flush with start in idle drops the start.
    @(negedge clk);
    start = 1'b1;
    op    = OpMultu;
    a     = 32'd9;
    b     = 32'd9;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    op    = OpNop;
    check("flush_start_dropped", busy, 0);

    // Reset mid-divide, then immediate restart.
    issue(OpDiv, 32'd20, 32'd3);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    push("divu_20_3", 32'd2, 32'd6, 1'b0);
    start = 1'b1;
    op    = OpDivu;
    a     = 32'd20;
    b     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    op    = OpNop;
    a     = '0;
    b     = '0;
    check("post_rst_accept", busy, 1);
    run_to_done("divu_20_3", 33);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
